// File: rtl/ps2_key_tracker.sv
// Generalised PS/2 Set-2 scan-code decoder with per-key level/pulse tracking and an event FIFO.
// Build option: define PS2_REPEAT_FILTER_EN to keep typematic repeats of held keys out of the FIFO.
module ps2_key_tracker #(
    parameter int                       NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0]    KEY_CODES      = {9'h01E, 9'h016, 9'h029, 9'h05A},
    parameter int                       FIFO_DEPTH     = 8,
    parameter int                       TIMEOUT_CYCLES = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_data_en,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [9:0]          evt_data,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_overflow,
    input  logic                clr_overflow,
    output logic                kbd_reinit
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PS2_REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t        state;
    logic [2:0]    skip_cnt;
    logic [31:0]   tmo_cnt;

    logic                done, brk, ext, held_hit, push, pop, full;
    logic [NUM_KEYS-1:0] match;

    // A byte completes a scan code only in these state/byte combinations.
    always_comb begin
        done = 1'b0;
        brk  = 1'b0;
        ext  = 1'b0;
        if (rx_data_en) begin
            case (state)
                IDLE:    done = !(rx_data inside {8'hE0, 8'hF0, 8'hE1, 8'hAA,
                                                  8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF});
                EXT:     begin
                             done = (rx_data != 8'hF0) && (rx_data != 8'h12);
                             ext  = 1'b1;
                         end
                BRK:     begin
                             done = 1'b1;
                             brk  = 1'b1;
                         end
                EXT_BRK: begin
                             done = (rx_data != 8'h12);
                             brk  = 1'b1;
                             ext  = 1'b1;
                         end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++)
            match[i] = (ext == KEY_CODES[9*i+8]) && (rx_data == KEY_CODES[9*i +: 8]);
    end

    assign held_hit = |(match & key_down);
    assign push     = done && !(FILTER && !brk && held_hit);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            tmo_cnt     <= '0;
            key_down    <= '0;
            key_press   <= '0;
            key_release <= '0;
            kbd_reinit  <= 1'b0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            kbd_reinit  <= 1'b0;
            if (rx_data_en) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        case (rx_data)
                            8'hE0: state <= EXT;
                            8'hF0: state <= BRK;
                            8'hE1: begin
                                state    <= PAUSE;
                                skip_cnt <= 3'd7;
                            end
                            8'hAA: begin
                                kbd_reinit <= 1'b1;
                                key_down   <= '0;
                            end
                            default: ;
                        endcase
                    end
                    EXT:     state <= (rx_data == 8'hF0) ? EXT_BRK : IDLE;
                    PAUSE: begin
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
                if (done) begin
                    if (brk) begin
                        key_down    <= key_down & ~match;
                        key_release <= key_down & match;
                    end else begin
                        key_down  <= key_down | match;
                        key_press <= match & ~key_down;
                    end
                end
            end else if (state != IDLE) begin
                // Abandon a stalled prefix so a lost byte cannot poison the next code.
                if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end
        end
    end

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] count;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign evt_valid = (wr_ptr != rd_ptr);
    assign pop       = evt_valid && evt_ready;
    assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && (!full || pop))
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (push && full && !pop)
                evt_overflow <= 1'b1;
            else if (clr_overflow)
                evt_overflow <= 1'b0;
        end
    end

    // Storage carries no reset; evt_data is masked while the FIFO is empty.
    always_ff @(posedge CLOCK_50) begin
        if (push && (!full || pop))
            mem[wr_ptr[AW-1:0]] <= {brk, ext, rx_data};
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits downstream of the PS/2 controller's byte receiver and replaces its fixed four-key decode with a generalised decoder.
- Consumes the received byte stream and decodes Set-2 make, break, E0-extended and E1 pause sequences.
- Tracks up to NUM_KEYS programmable keys as level and pulse outputs.
- Queues every completed scan code into an event FIFO for game/benchmark logic.

Parameters:
- NUM_KEYS, 4, number of tracked keys, 1..32.
- KEY_CODES, {9'h01E,9'h016,9'h029,9'h05A}, packed NUM_KEYS*9 bits; key i = bits [9i+8:9i], bit 8 = extended (E0) flag, bits 7:0 = code. Default order: key0 = Enter, key1 = Space, key2 = '1', key3 = '2'.
- FIFO_DEPTH, 8, event FIFO entries, power of 2, >=2.
- TIMEOUT_CYCLES, 50000000, idle cycles after which a partial prefix sequence is abandoned (1 s at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte
- rx_data_en  in  1  one-cycle strobe, rx_data valid
- key_down  out  NUM_KEYS  level, key currently held
- key_press  out  NUM_KEYS  one-cycle pulse on make of a key not already down
- key_release  out  NUM_KEYS  one-cycle pulse on break of a key that is down
- evt_data  out  10  {is_break, is_ext, code[7:0]} at FIFO head
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  pop when evt_valid && evt_ready
- evt_overflow  out  1  sticky: event dropped because FIFO was full
- clr_overflow  in  1  clears evt_overflow
- kbd_reinit  out  1  one-cycle pulse on BAT byte 0xAA

Behaviour:
- Reset and clock: reset is synchronous, active-high; the clock is CLOCK_50.
- Reset values: every output is 0; FIFO is empty; FSM is in IDLE; timeout counter is 0.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - Transitions advance only on rx_data_en.
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter = 7.
  - IDLE: AA -> pulse kbd_reinit and clear all key_down (no press/release pulses).
  - IDLE: FA, EE, FE, 00, FF are ignored.
  - IDLE: any other byte is a complete make (ext=0) -> IDLE.
  - EXT: F0 -> EXT_BRK; 12 (fake shift) -> IDLE with no event; other -> make (ext=1) -> IDLE.
  - BRK: any byte is a break (ext=0) -> IDLE.
  - EXT_BRK: 12 -> IDLE with no event; other -> break (ext=1) -> IDLE.
  - PAUSE: decrement on each byte; return to IDLE when the counter reaches 0. No event and no key update.
- Timeout:
  - The counter runs in every non-IDLE state and is cleared on each rx_data_en.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE with nothing emitted.
- Completion: a complete scan code is {brk, ext, code}. Key i matches when ext == KEY_CODES[9i+8] && code == KEY_CODES[9i+7:9i]. Multiple matching keys all update.
- Latency: if rx_data_en is high at cycle N and completes a code, then at N+1:
  - key_down, key_press and key_release are updated;
  - the event is written and evt_valid is high if the FIFO was empty.
- key_press / key_release:
  - key_press fires only on a 0->1 transition of key_down.
  - key_release fires only on a 1->0 transition.
  - A break for a key that is not down changes nothing and produces no pulse.
- FIFO contents: every completed code (matched or not) is pushed, subject to the feature below. The FIFO is first-word-fall-through; evt_data is valid whenever evt_valid is high.
- FIFO full:
  - Push while full with no simultaneous pop: the event is dropped and evt_overflow is set.
  - Push and pop in the same cycle while full: both happen and there is no overflow.
  - Pop while empty: ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- evt_overflow: clr_overflow clears it. If clr_overflow and a new overflow occur in the same cycle, the set wins.
- Mid-sequence reset: the FSM returns to IDLE and the partial sequence is discarded.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined: a make for a tracked key whose key_down is already 1 (typematic repeat) is not pushed to the FIFO. Untracked codes are always pushed.
- Not defined: every repeat make is pushed as its own event. key_press behaviour is identical in both builds.

Test Plan:
- Bytes 5A, F0 5A -> key_down[0]=1 and key_press[0] pulse at cycle N+1 after 5A, then key_release[0] pulse. FIFO holds 10'h05A then 10'h25A.
- Bytes E0 75, E0 F0 75 -> FIFO holds 10'h175 then 10'h375; key_down unchanged. Same test with KEY_CODES key0 = 9'h175 -> key_down[0] goes 1 then 0.
- Bytes E1 14 77 E1 F0 14 F0 77, then 29 -> only 10'h029 is queued and key_down[1]=1.
- 9 makes of 16 with evt_ready=0 and the filter macro off -> 8 entries, evt_overflow=1. Then one pop together with one push -> still 8 entries; clr_overflow -> 0.
- Same 9 makes with PS2_REPEAT_FILTER_EN defined -> FIFO holds 1 entry, no overflow.
- Byte E0 then silence for TIMEOUT_CYCLES (set to 100) then 29 -> 10'h029 with ext=0. Separately, AA while key0 is held -> kbd_reinit pulse, key_down=0, no release pulse.
